// File: rtl/raw_bayer_tx.sv
`default_nettype none
// ============================================================================
//  Module   : raw_bayer_tx
//  Brief    : Raw Bayer (GRBG) test-pattern frame transmitter in the CCD
//             pixel-clock domain. Emits 10-bit pixels qualified by LVAL/FVAL,
//             with column/line indices and an end-of-frame pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module raw_bayer_tx #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int H_BLANK  = 160,
   parameter int FV_LEAD  = 16,
   parameter int FV_TAIL  = 16,
   parameter int V_BLANK  = 16000
) (
   input  logic        CCD_PIXCLK,
   input  logic        RST,
   input  logic        EN,
   input  logic [1:0]  PATTERN_SEL,
   output logic [9:0]  mCCD_DATA,
   output logic        mCCD_LVAL,
   output logic        mCCD_FVAL,
   output logic [10:0] X_Cont,
   output logic [10:0] Y_Cont,
   output logic        FRAME_DONE
);

   // Timer reload values: a timed state lasting N clocks loads N-1.
   localparam logic [15:0] c_LEAD_LD  = 16'(FV_LEAD - 1);
   localparam logic [15:0] c_HBL_LD   = 16'(H_BLANK - 1);
   localparam logic [15:0] c_TAIL_LD  = 16'(FV_TAIL - 1);
   localparam logic [15:0] c_VBL_LD   = 16'(V_BLANK - 1);
   localparam logic [10:0] c_X_LAST   = 11'(H_ACTIVE - 1);
   localparam logic [10:0] c_Y_LAST   = 11'(V_ACTIVE - 1);
   localparam logic [10:0] c_BAR_LAST = 11'(H_ACTIVE / 8 - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEAD   = 3'd1,
      S_LINE   = 3'd2,
      S_HBLANK = 3'd3,
      S_TAIL   = 3'd4,
      S_VBLANK = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        w_tload;
   logic [15:0] w_tval;
   logic        w_latch;

   logic [15:0] r_timer;
   logic [10:0] r_x;
   logic [10:0] r_y;
   logic [10:0] r_bcnt;
   logic [2:0]  r_bar;
   logic [1:0]  r_pat;
   logic        r_vb_first;

   logic        w_tzero;
   logic        w_r;
   logic        w_g;
   logic        w_b;
   logic        w_bar_on;
   logic [9:0]  w_sum;
   logic [9:0]  w_pix;
   logic        w_fv;

   assign w_tzero = (r_timer == 16'd0);

   // State register.
   always_ff @(posedge CCD_PIXCLK or posedge RST) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic, timer reload requests and pattern latch strobe.
   always_comb begin
      w_next  = r_state;
      w_tload = 1'b0;
      w_tval  = 16'd0;
      w_latch = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (EN) begin
               w_next  = S_LEAD;
               w_tload = 1'b1;
               w_tval  = c_LEAD_LD;
               w_latch = 1'b1;
            end
         end
         S_LEAD: begin
            if (w_tzero) begin
               w_next = S_LINE;
            end
         end
         S_LINE: begin
            if (r_x == c_X_LAST) begin
               w_next  = S_HBLANK;
               w_tload = 1'b1;
               w_tval  = c_HBL_LD;
            end
         end
         S_HBLANK: begin
            if (w_tzero) begin
               if (r_y < c_Y_LAST) begin
                  w_next = S_LINE;
               end else begin
                  w_next  = S_TAIL;
                  w_tload = 1'b1;
                  w_tval  = c_TAIL_LD;
               end
            end
         end
         S_TAIL: begin
            if (w_tzero) begin
               w_next  = S_VBLANK;
               w_tload = 1'b1;
               w_tval  = c_VBL_LD;
            end
         end
         S_VBLANK: begin
            if (w_tzero) begin
               if (EN) begin
                  w_next  = S_LEAD;
                  w_tload = 1'b1;
                  w_tval  = c_LEAD_LD;
                  w_latch = 1'b1;
               end else begin
                  w_next = S_IDLE;
               end
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Shared down-timer for LEAD, HBLANK, TAIL and VBLANK.
   always_ff @(posedge CCD_PIXCLK or posedge RST) begin
      if (RST) begin
         r_timer <= 16'd0;
      end else if (w_tload) begin
         r_timer <= w_tval;
      end else if (!w_tzero) begin
         r_timer <= r_timer - 16'd1;
      end
   end

   // Column counter: runs across the active line, parked at 0 otherwise.
   always_ff @(posedge CCD_PIXCLK or posedge RST) begin
      if (RST) begin
         r_x <= 11'd0;
      end else if (r_state == S_LINE && w_next == S_LINE) begin
         r_x <= r_x + 11'd1;
      end else begin
         r_x <= 11'd0;
      end
   end

   // Line counter: advances at the end of each H_BLANK, cleared between frames.
   always_ff @(posedge CCD_PIXCLK or posedge RST) begin
      if (RST) begin
         r_y <= 11'd0;
      end else if (r_state == S_HBLANK && w_next == S_LINE) begin
         r_y <= r_y + 11'd1;
      end else if (w_next == S_LEAD || w_next == S_VBLANK || w_next == S_IDLE) begin
         r_y <= 11'd0;
      end
   end

   // Bar index tracking: a pixel-within-bar counter avoids a divider.
   always_ff @(posedge CCD_PIXCLK or posedge RST) begin
      if (RST) begin
         r_bcnt <= 11'd0;
         r_bar  <= 3'd0;
      end else if (r_state == S_LINE) begin
         if (r_bcnt == c_BAR_LAST) begin
            r_bcnt <= 11'd0;
            r_bar  <= r_bar + 3'd1;
         end else begin
            r_bcnt <= r_bcnt + 11'd1;
         end
      end else begin
         r_bcnt <= 11'd0;
         r_bar  <= 3'd0;
      end
   end

   // Pattern select is captured only when a frame starts.
   always_ff @(posedge CCD_PIXCLK or posedge RST) begin
      if (RST) begin
         r_pat <= 2'd0;
      end else if (w_latch) begin
         r_pat <= PATTERN_SEL;
      end
   end

   // Marks the first VBLANK cycle so the end-of-frame pulse lines up with FVAL.
   always_ff @(posedge CCD_PIXCLK or posedge RST) begin
      if (RST) begin
         r_vb_first <= 1'b0;
      end else begin
         r_vb_first <= (r_state == S_TAIL) && (w_next == S_VBLANK);
      end
   end

   // Pixel value for the current (x, y) with GRBG re-mosaic of the colour bars.
   always_comb begin
      w_r = ~r_bar[1];
      w_g = ~r_bar[2];
      w_b = ~r_bar[0];
      if (!r_y[0]) begin
         w_bar_on = r_x[0] ? w_r : w_g;
      end else begin
         w_bar_on = r_x[0] ? w_g : w_b;
      end
      w_sum = r_x[9:0] + r_y[9:0];
      case (r_pat)
         2'd0:    w_pix = w_bar_on ? 10'h3FF : 10'h000;
         2'd1:    w_pix = w_sum;
         2'd2:    w_pix = (r_x[4] ^ r_y[4]) ? 10'h3FF : 10'h000;
         default: w_pix = 10'h200;
      endcase
   end

   assign w_fv = (r_state != S_IDLE) && (r_state != S_VBLANK);

   // Output registers: every output is taken from the same state snapshot.
   always_ff @(posedge CCD_PIXCLK or posedge RST) begin
      if (RST) begin
         mCCD_FVAL  <= 1'b0;
         mCCD_LVAL  <= 1'b0;
         mCCD_DATA  <= 10'd0;
         X_Cont     <= 11'd0;
         Y_Cont     <= 11'd0;
         FRAME_DONE <= 1'b0;
      end else begin
         mCCD_FVAL  <= w_fv;
         mCCD_LVAL  <= (r_state == S_LINE);
         mCCD_DATA  <= (r_state == S_LINE) ? w_pix : 10'd0;
         X_Cont     <= (r_state == S_LINE) ? r_x : 11'd0;
         Y_Cont     <= w_fv ? r_y : 11'd0;
         FRAME_DONE <= r_vb_first;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_raw_bayer_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_raw_bayer_tx
//  Brief    : Self-checking bench for raw_bayer_tx (timing, patterns, latch,
//             enable stop, async reset) using an expected-pixel scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_raw_bayer_tx;

   typedef struct packed {
      logic [9:0]  d;
      logic [10:0] x;
      logic [10:0] y;
   } exp_t;

   logic        clk = 1'b0;
   logic        RST = 1'b1;
   logic        EN0 = 1'b0;
   logic        EN1 = 1'b0;
   logic        EN2 = 1'b0;
   logic [1:0]  SEL = 2'd0;
   int          dsel = 0;

   logic [9:0]  d0, d1, d2;
   logic        l0, l1, l2, f0, f1, f2, k0, k1, k2;
   logic [10:0] x0, x1, x2, y0, y1, y2;

   logic [9:0]  m_data;
   logic        m_lval, m_fval, m_done;
   logic [10:0] m_x, m_y;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   raw_bayer_tx #(.H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4), .FV_LEAD(2), .FV_TAIL(2), .V_BLANK(10)) u_dut (
      .CCD_PIXCLK(clk), .RST(RST), .EN(EN0), .PATTERN_SEL(SEL),
      .mCCD_DATA(d0), .mCCD_LVAL(l0), .mCCD_FVAL(f0), .X_Cont(x0), .Y_Cont(y0), .FRAME_DONE(k0));

   raw_bayer_tx #(.H_ACTIVE(1024), .V_ACTIVE(2), .H_BLANK(4), .FV_LEAD(2), .FV_TAIL(2), .V_BLANK(10)) u_ramp (
      .CCD_PIXCLK(clk), .RST(RST), .EN(EN1), .PATTERN_SEL(SEL),
      .mCCD_DATA(d1), .mCCD_LVAL(l1), .mCCD_FVAL(f1), .X_Cont(x1), .Y_Cont(y1), .FRAME_DONE(k1));

   raw_bayer_tx #(.H_ACTIVE(64), .V_ACTIVE(32), .H_BLANK(4), .FV_LEAD(2), .FV_TAIL(2), .V_BLANK(10)) u_chk (
      .CCD_PIXCLK(clk), .RST(RST), .EN(EN2), .PATTERN_SEL(SEL),
      .mCCD_DATA(d2), .mCCD_LVAL(l2), .mCCD_FVAL(f2), .X_Cont(x2), .Y_Cont(y2), .FRAME_DONE(k2));

   // Route the instance under test to the common monitor signals.
   always_comb begin
      case (dsel)
         1: begin m_data = d1; m_lval = l1; m_fval = f1; m_x = x1; m_y = y1; m_done = k1; end
         2: begin m_data = d2; m_lval = l2; m_fval = f2; m_x = x2; m_y = y2; m_done = k2; end
         default: begin m_data = d0; m_lval = l0; m_fval = f0; m_x = x0; m_y = y0; m_done = k0; end
      endcase
   end

   // Reference pixel model written from the pattern definitions.
   function automatic logic [9:0] exp_pix(input int pat, input int x, input int y, input int hact);
      int   b;
      logic r, g, bl, on;
      b  = x / (hact / 8);
      r  = ((b & 2) == 0);
      g  = ((b & 4) == 0);
      bl = ((b & 1) == 0);
      if (y % 2 == 0) on = (x % 2 == 0) ? g : r;
      else            on = (x % 2 == 0) ? bl : g;
      case (pat)
         0:       return on ? 10'h3FF : 10'h000;
         1:       return 10'((x + y) % 1024);
         2:       return ((((x / 16) + (y / 16)) % 2) == 1) ? 10'h3FF : 10'h000;
         default: return 10'h200;
      endcase
   endfunction

   task automatic push_frame(input int pat, input int hact, input int vact);
      exp_t e;
      for (int y = 0; y < vact; y++) begin
         for (int x = 0; x < hact; x++) begin
            e.d = exp_pix(pat, x, y, hact);
            e.x = 11'(x);
            e.y = 11'(y);
            sb.push_back(e);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_total++; if (f0 !== 1'b0) $display("FAIL rst_fval: got %b want 0", f0); else n_pass++;
      n_total++; if (l0 !== 1'b0) $display("FAIL rst_lval: got %b want 0", l0); else n_pass++;
      n_total++; if (d0 !== 10'd0) $display("FAIL rst_data: got %h want 000", d0); else n_pass++;
      n_total++; if (x0 !== 11'd0) $display("FAIL rst_x: got %0d want 0", x0); else n_pass++;
      n_total++; if (y0 !== 11'd0) $display("FAIL rst_y: got %0d want 0", y0); else n_pass++;
      n_total++; if (k0 !== 1'b0) $display("FAIL rst_done: got %b want 0", k0); else n_pass++;
      n_total++; if ({f1, f2} !== 2'b00) $display("FAIL rst_fval_others: got %b want 00", {f1, f2}); else n_pass++;
      RST = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_total++; if (f0 !== 1'b0) $display("FAIL idle_fval: got %b want 0 (cycle %0d)", f0, k); else n_pass++;
      end
   endtask

   task automatic test_frame_timing();
      exp_t e;
      logic ef, el, ed;
      int   p;
      dsel = 0;
      SEL  = 2'd0;
      push_frame(0, 8, 4);
      push_frame(0, 8, 4);
      EN0 = 1'b1;
      for (int k = 0; k < 230; k++) begin
         if (k == 70) begin SEL = 2'd3; push_frame(3, 8, 4); end
         if (k == 140) EN0 = 1'b0;
         @(negedge clk);
         ef = 1'b0; el = 1'b0; ed = 1'b0;
         if (k >= 1 && (k - 1) / 62 < 3) begin
            p  = (k - 1) % 62;
            ef = (p < 52);
            el = (p >= 2 && p < 50 && ((p - 2) % 12) < 8);
            ed = (p == 52);
         end
         n_total++; if (m_fval !== ef) $display("FAIL tim_fval: cycle %0d got %b want %b", k, m_fval, ef); else n_pass++;
         n_total++; if (m_lval !== el) $display("FAIL tim_lval: cycle %0d got %b want %b", k, m_lval, el); else n_pass++;
         n_total++; if (m_done !== ed) $display("FAIL tim_done: cycle %0d got %b want %b", k, m_done, ed); else n_pass++;
         if (m_lval === 1'b1) begin
            n_total++;
            if (sb.size() == 0) $display("FAIL pix_extra: got pixel x=%0d y=%0d want none", m_x, m_y);
            else begin
               e = sb.pop_front();
               if (m_data !== e.d || m_x !== e.x || m_y !== e.y)
                  $display("FAIL pix: got d=%h x=%0d y=%0d want d=%h x=%0d y=%0d", m_data, m_x, m_y, e.d, e.x, e.y);
               else n_pass++;
            end
         end else begin
            n_total++; if (m_data !== 10'd0 || m_x !== 11'd0) $display("FAIL blank: cycle %0d got d=%h x=%0d want 0", k, m_data, m_x); else n_pass++;
         end
         if (m_fval !== 1'b1) begin
            n_total++; if (m_y !== 11'd0) $display("FAIL y_outside: cycle %0d got %0d want 0", k, m_y); else n_pass++;
         end
      end
      n_total++; if (sb.size() != 0) $display("FAIL tim_drain: got %0d left want 0", sb.size()); else n_pass++;
      sb.delete();
   endtask

   task automatic test_ramp();
      exp_t e;
      int   ncyc;
      for (int ph = 0; ph < 2; ph++) begin
         dsel = ph;
         SEL  = 2'd1;
         if (ph == 0) begin push_frame(1, 8, 4);    EN0 = 1'b1; ncyc = 80;   end
         else         begin push_frame(1, 1024, 2); EN1 = 1'b1; ncyc = 2100; end
         for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (k == 5) begin EN0 = 1'b0; EN1 = 1'b0; end
            if (m_lval === 1'b1) begin
               n_total++;
               if (sb.size() == 0) $display("FAIL ramp_extra: got pixel x=%0d y=%0d want none", m_x, m_y);
               else begin
                  e = sb.pop_front();
                  if (m_data !== e.d || m_x !== e.x || m_y !== e.y)
                     $display("FAIL ramp_pix: got d=%h x=%0d y=%0d want d=%h x=%0d y=%0d", m_data, m_x, m_y, e.d, e.x, e.y);
                  else n_pass++;
               end
               if (m_x == 11'd1023 && m_y == 11'd1) begin
                  n_total++; if (m_data !== 10'h000) $display("FAIL ramp_wrap: got %h want 000", m_data); else n_pass++;
               end
            end
         end
         n_total++; if (sb.size() != 0) $display("FAIL ramp_drain: phase %0d got %0d left want 0", ph, sb.size()); else n_pass++;
         sb.delete();
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      logic found;
      found = 1'b0;
      dsel  = 0;
      SEL   = 2'd0;
      push_frame(0, 8, 4);
      EN0 = 1'b1;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge clk);
         if (m_lval === 1'b1) begin
            n_total++;
            if (sb.size() == 0) $display("FAIL rm_extra: got pixel x=%0d y=%0d want none", m_x, m_y);
            else begin
               e = sb.pop_front();
               if (m_data !== e.d || m_x !== e.x || m_y !== e.y)
                  $display("FAIL rm_pix: got d=%h x=%0d y=%0d want d=%h x=%0d y=%0d", m_data, m_x, m_y, e.d, e.x, e.y);
               else n_pass++;
            end
            if (m_x == 11'd3 && m_y == 11'd1) found = 1'b1;
         end
      end
      n_total++; if (found !== 1'b1) $display("FAIL rm_reach: got found=%b want 1", found); else n_pass++;
      RST = 1'b1;
      #1;
      n_total++; if ({m_fval, m_lval} !== 2'b00) $display("FAIL rm_async_vals: got %b want 00", {m_fval, m_lval}); else n_pass++;
      n_total++; if (m_data !== 10'd0 || m_x !== 11'd0 || m_y !== 11'd0)
         $display("FAIL rm_async_dxy: got d=%h x=%0d y=%0d want 0", m_data, m_x, m_y); else n_pass++;
      sb.delete();
      @(negedge clk);
      RST = 1'b0;
      push_frame(0, 8, 4);
      @(negedge clk);
      n_total++; if (m_fval !== 1'b0) $display("FAIL rm_lat0: got %b want 0", m_fval); else n_pass++;
      @(negedge clk);
      n_total++; if (m_fval !== 1'b1) $display("FAIL rm_lat1: got %b want 1", m_fval); else n_pass++;
      for (int k = 0; k < 70; k++) begin
         @(negedge clk);
         if (k == 3) EN0 = 1'b0;
         if (m_lval === 1'b1) begin
            n_total++;
            if (sb.size() == 0) $display("FAIL rm2_extra: got pixel x=%0d y=%0d want none", m_x, m_y);
            else begin
               e = sb.pop_front();
               if (m_data !== e.d || m_x !== e.x || m_y !== e.y)
                  $display("FAIL rm2_pix: got d=%h x=%0d y=%0d want d=%h x=%0d y=%0d", m_data, m_x, m_y, e.d, e.x, e.y);
               else n_pass++;
            end
         end
      end
      n_total++; if (sb.size() != 0) $display("FAIL rm_drain: got %0d left want 0", sb.size()); else n_pass++;
      n_total++; if (m_fval !== 1'b0) $display("FAIL rm_idle: got %b want 0", m_fval); else n_pass++;
      sb.delete();
   endtask

   task automatic test_checker();
      exp_t e;
      dsel = 2;
      SEL  = 2'd2;
      push_frame(2, 64, 32);
      EN2 = 1'b1;
      for (int k = 0; k < 2220; k++) begin
         @(negedge clk);
         if (k == 5) EN2 = 1'b0;
         if (m_lval === 1'b1) begin
            n_total++;
            if (sb.size() == 0) $display("FAIL chk_extra: got pixel x=%0d y=%0d want none", m_x, m_y);
            else begin
               e = sb.pop_front();
               if (m_data !== e.d || m_x !== e.x || m_y !== e.y)
                  $display("FAIL chk_pix: got d=%h x=%0d y=%0d want d=%h x=%0d y=%0d", m_data, m_x, m_y, e.d, e.x, e.y);
               else n_pass++;
            end
         end
      end
      n_total++; if (sb.size() != 0) $display("FAIL chk_drain: got %0d left want 0", sb.size()); else n_pass++;
      sb.delete();
   endtask

   initial begin
      test_reset();
      test_frame_timing();
      test_ramp();
      test_reset_mid();
      test_checker();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
